pxmon: RTL and testbench

Pixel-timing monitor on the sink side of the pixel-clock strobe interface. It consumes the `dphstart`/`dpvstart`/`dmastart` strobes produced by the pixel-clock generator and recovers the actual line length in `clk` cycles and the number of lines per frame. It checks the strobes against the programmed vertical total and against each other, then reports lock and sticky error status to the control registers. It is passive: it never drives the strobes.

---
 rtl/pxmon.sv | 175 +++++++++++++++++
 tb/tb_pxmon.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pxmon.sv
// Pixel-timing monitor: measures line length and lines per frame from the pixel strobes, checks them and reports lock/error status.
// Optional macro PXMON_DMACHK_EN compiles in the dmastart placement check (err[1]).
module pxmon #(
  parameter int LOCKN = 2,
  parameter int CTRW  = 20
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            dphstart,
  input  logic            dpvstart,
  input  logic            dmastart,
  input  logic [15:0]     vtot,
  input  logic            clrerr,
  output logic [CTRW-1:0] linemin,
  output logic [CTRW-1:0] linemax,
  output logic [15:0]     nlines,
  output logic            locked,
  output logic [2:0]      err,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    COUNT  = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam int CW = (LOCKN > 1) ? $clog2(LOCKN + 1) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CTRW-1:0] lctr_q, lctr_d;
  logic [CTRW-1:0] run_min_q, run_min_d;
  logic [CTRW-1:0] run_max_q, run_max_d;
  logic [CTRW-1:0] base_min, base_max;
  logic [CTRW-1:0] linemin_q, linemin_d;
  logic [CTRW-1:0] linemax_q, linemax_d;
  logic [15:0]     yc_q, yc_d;
  logic [15:0]     nlines_q, nlines_d;
  logic [2:0]      err_q, err_d;
  logic [2:0]      ev;
  logic            first_line_q, first_line_d;
  logic            first_frame_q, first_frame_d;
  logic            boundary, chk_bnd;

  assign boundary = dphstart & dpvstart;
  // The very first boundary after reset only aligns the frame counters.
  assign chk_bnd  = boundary & ~first_frame_q;

  assign ev[0] = dpvstart & ~dphstart;
  assign ev[2] = chk_bnd & ({1'b0, yc_q} != ({1'b0, vtot} + 17'd1));

`ifdef PXMON_DMACHK_EN
  logic dma_pend_q, dma_pend_d;

  // dma_pend remembers whether the most recent line start carried dmastart.
  assign ev[1] = (dmastart & ~dphstart)
               | (dphstart & dma_pend_q & ~dpvstart)
               | (chk_bnd & ~dma_pend_q);
  assign dma_pend_d = dphstart ? dmastart : dma_pend_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) dma_pend_q <= 1'b0;
    else         dma_pend_q <= dma_pend_d;
  end
`else
  logic dma_unused;
  assign dma_unused = dmastart;
  assign ev[1]      = 1'b0;
`endif

  assign base_min = boundary ? '1 : run_min_q;
  assign base_max = boundary ? '0 : run_max_q;

  always_comb begin
    lctr_d        = lctr_q;
    run_min_d     = run_min_q;
    run_max_d     = run_max_q;
    yc_d          = yc_q;
    first_line_d  = first_line_q;
    first_frame_d = first_frame_q;
    linemin_d     = linemin_q;
    linemax_d     = linemax_q;
    nlines_d      = nlines_q;
    err_d         = (clrerr ? 3'b000 : err_q) | ev;

    if (dphstart) begin
      lctr_d       = CTRW'(1);
      first_line_d = 1'b0;
      run_min_d    = base_min;
      run_max_d    = base_max;
      if (!first_line_q && (lctr_q < base_min)) run_min_d = lctr_q;
      if (!first_line_q && (lctr_q > base_max)) run_max_d = lctr_q;
      if (yc_q != 16'hFFFF) yc_d = yc_q + 16'd1;
    end else if (lctr_q != '1) begin
      lctr_d = lctr_q + 1'b1;
    end

    if (boundary) begin
      yc_d          = 16'd1;
      first_frame_d = 1'b0;
    end

    if (chk_bnd) begin
      nlines_d  = yc_q;
      linemin_d = run_min_q;
      linemax_d = run_max_q;
    end
  end

  // Any error event drops lock at once; it takes priority over boundary progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (|ev) begin
      state_d = UNLOCK;
      cnt_d   = '0;
    end else if (boundary) begin
      case (state_q)
        UNLOCK: begin
          state_d = COUNT;
          cnt_d   = '0;
        end
        COUNT: begin
          if (cnt_q == CW'(LOCKN - 1)) begin
            state_d = LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCK:    state_d = LOCK;
        default: state_d = UNLOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= UNLOCK;
      cnt_q         <= '0;
      lctr_q        <= '0;
      run_min_q     <= '1;
      run_max_q     <= '0;
      linemin_q     <= '0;
      linemax_q     <= '0;
      yc_q          <= '0;
      nlines_q      <= '0;
      err_q         <= '0;
      first_line_q  <= 1'b1;
      first_frame_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lctr_q        <= lctr_d;
      run_min_q     <= run_min_d;
      run_max_q     <= run_max_d;
      linemin_q     <= linemin_d;
      linemax_q     <= linemax_d;
      yc_q          <= yc_d;
      nlines_q      <= nlines_d;
      err_q         <= err_d;
      first_line_q  <= first_line_d;
      first_frame_q <= first_frame_d;
    end
  end

  assign linemin   = linemin_q;
  assign linemax   = linemax_q;
  assign nlines    = nlines_q;
  assign err       = err_q;
  assign locked    = (state_q == LOCK);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pxmon.sv
// Directed bench for pxmon: regular, fractional and length-1 lines, error injection, vtot mismatch and mid-frame reset.
module tb_pxmon;

  logic        clk;
  logic        resetn;
  logic        dphstart;
  logic        dpvstart;
  logic        dmastart;
  logic [15:0] vtot;
  logic        clrerr;
  logic [19:0] linemin;
  logic [19:0] linemax;
  logic [15:0] nlines;
  logic        locked;
  logic [2:0]  err;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  pxmon #(.LOCKN(2), .CTRW(20)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .dphstart  (dphstart),
    .dpvstart  (dpvstart),
    .dmastart  (dmastart),
    .vtot      (vtot),
    .clrerr    (clrerr),
    .linemin   (linemin),
    .linemax   (linemax),
    .nlines    (nlines),
    .locked    (locked),
    .err       (err),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge after the rising one.
  task automatic cyc(input logic h, input logic v, input logic d);
    dphstart = h;
    dpvstart = v;
    dmastart = d;
    @(negedge clk);
  endtask

  task automatic line(input int len, input logic v, input logic d);
    cyc(1'b1, v, d);
    for (int i = 1; i < len; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Four lines with lengths la,lb,la,lb; dpvstart on the first, dmastart on the last when dma_ok.
  task automatic frame(input int la, input int lb, input logic dma_ok);
    line(la, 1'b1, 1'b0);
    line(lb, 1'b0, 1'b0);
    line(la, 1'b0, 1'b0);
    line(lb, 1'b0, dma_ok);
  endtask

  task automatic pulse_clr();
    clrerr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    clrerr = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    resetn   = 1'b0;
    dphstart = 1'b0;
    dpvstart = 1'b0;
    dmastart = 1'b0;
    clrerr   = 1'b0;
    vtot     = 16'd3;
    repeat (3) @(negedge clk);
    check("rst_linemin", 32'(linemin), 32'd0);
    check("rst_linemax", 32'(linemax), 32'd0);
    check("rst_nlines",  32'(nlines),  32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_locked",  32'(locked),  32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    resetn = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Regular timing: sync boundary, then two good boundaries to lock.
    frame(4, 4, 1'b1);
    check("sync_nlines", 32'(nlines), 32'd0);
    check("sync_locked", 32'(locked), 32'd0);
    frame(4, 4, 1'b1);
    check("reg_nlines",  32'(nlines),  32'd4);
    check("reg_linemin", 32'(linemin), 32'd4);
    check("reg_linemax", 32'(linemax), 32'd4);
    check("reg_locked1", 32'(locked),  32'd0);
    frame(4, 4, 1'b1);
    check("reg_locked2", 32'(locked),  32'd1);
    check("reg_err",     32'(err),     32'd0);

    // Fractional timing 3,4.
    frame(3, 4, 1'b1);
    frame(3, 4, 1'b1);
    check("frac_linemin", 32'(linemin), 32'd3);
    check("frac_linemax", 32'(linemax), 32'd4);
    check("frac_nlines",  32'(nlines),  32'd4);
    check("frac_locked",  32'(locked),  32'd1);

    // Back-to-back line starts (length 1) are legal.
    frame(1, 5, 1'b1);
    frame(1, 5, 1'b1);
    check("len1_linemin", 32'(linemin), 32'd1);
    check("len1_linemax", 32'(linemax), 32'd5);
    check("len1_err",     32'(err),     32'd0);
    check("len1_locked",  32'(locked),  32'd1);

    // Lone dpvstart mid-line.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("lone_vs_err",    32'(err),    32'd1);
    check("lone_vs_locked", 32'(locked), 32'd0);
    pulse_clr();
    check("clr_err", 32'(err), 32'd0);
    clrerr = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    clrerr = 1'b0;
    check("clr_vs_same_cycle", 32'(err), 32'd1);
    pulse_clr();
    check("clr_err2", 32'(err), 32'd0);
    line(4, 1'b0, 1'b0);
    line(4, 1'b0, 1'b0);
    line(4, 1'b0, 1'b1);
    frame(4, 4, 1'b1);
    frame(4, 4, 1'b1);
    check("relock_pending", 32'(locked), 32'd0);
    frame(4, 4, 1'b1);
    check("relock_locked",  32'(locked), 32'd1);
    check("relock_err",     32'(err),    32'd0);
    check("relock_linemax", 32'(linemax), 32'd4);

    // Missing dmastart before a frame start.
    frame(4, 4, 1'b0);
    frame(4, 4, 1'b1);
`ifdef PXMON_DMACHK_EN
    check("nodma_err",    32'(err),    32'd2);
    check("nodma_locked", 32'(locked), 32'd0);
`else
    check("nodma_err",    32'(err),    32'd0);
    check("nodma_locked", 32'(locked), 32'd1);
`endif
    pulse_clr();
    check("nodma_clr", 32'(err), 32'd0);
    frame(4, 4, 1'b1);
    frame(4, 4, 1'b1);
    frame(4, 4, 1'b1);
    check("nodma_relock", 32'(locked), 32'd1);

    // vtot programmed one higher than the source.
    vtot = 16'd4;
    frame(4, 4, 1'b1);
    check("vtot_err",    32'(err),    32'd4);
    check("vtot_nlines", 32'(nlines), 32'd4);
    check("vtot_locked", 32'(locked), 32'd0);
    vtot = 16'd3;
    pulse_clr();
    check("vtot_clr", 32'(err), 32'd0);
    frame(4, 4, 1'b1);
    frame(4, 4, 1'b1);
    frame(4, 4, 1'b1);
    check("vtot_relock", 32'(locked), 32'd1);

    // Reset in mid-frame while locked.
    line(4, 1'b1, 1'b0);
    line(4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    check("mrst_linemin", 32'(linemin), 32'd0);
    check("mrst_linemax", 32'(linemax), 32'd0);
    check("mrst_nlines",  32'(nlines),  32'd0);
    check("mrst_err",     32'(err),     32'd0);
    check("mrst_locked",  32'(locked),  32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    line(4, 1'b0, 1'b0);
    line(4, 1'b0, 1'b1);
    frame(4, 4, 1'b1);
    check("mrst_sync_nlines", 32'(nlines), 32'd0);
    check("mrst_sync_locked", 32'(locked), 32'd0);
    frame(4, 4, 1'b1);
    check("mrst_nlines2",  32'(nlines),  32'd4);
    check("mrst_linemin2", 32'(linemin), 32'd4);
    check("mrst_linemax2", 32'(linemax), 32'd4);
    check("mrst_locked2",  32'(locked),  32'd0);
    check("mrst_err2",     32'(err),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
